// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder sequencer: one shared digit stage, LSD first.
// Optional illegal-digit detection is built when BCD_DIGIT_CHECK_EN is defined.
module bcd_serial_add_ctrl #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned CntW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_acc;
  logic [W-1:0]    w_acc_next;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_carry;
  logic [CntW-1:0] r_cnt;
  logic [3:0]      w_da;
  logic [3:0]      w_db;
  logic [3:0]      w_s;
  logic [4:0]      w_t;
  logic            w_dc;
  logic            w_accept;
  logic            w_last;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_next = StRun;
      StRun:   if (r_cnt == LastCnt) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (r_state == StRun);
    done = (r_state == StDone);
  end

  assign w_accept = (r_state == StIdle) && start;
  assign w_last   = (r_state == StRun) && (r_cnt == LastCnt);

  // Operands shift right each RUN cycle, so the current digit is always at the bottom.
  assign w_da = r_a[3:0];
  assign w_db = r_b[3:0];
  assign w_t  = {1'b0, w_da} + {1'b0, w_db} + {4'b0000, r_carry};
  assign w_dc = w_t[4] | (w_t[3] & (w_t[2] | w_t[1]));
  assign w_s  = w_t[3:0] + (w_dc ? 4'd6 : 4'd0);

  always_comb begin
    w_acc_next = r_acc;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_cnt == CntW'(k)) w_acc_next[4*k +: 4] = w_s;
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic r_bad;
  logic r_err;
  logic w_digit_bad;

  assign w_digit_bad = (w_da > 4'd9) || (w_db > 4'd9);
  assign err         = r_err;
`else
  assign err = 1'b0;
`endif

  // Datapath: latch on accept, step one digit per RUN cycle, publish only at the last step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
`ifdef BCD_DIGIT_CHECK_EN
      r_bad   <= 1'b0;
      r_err   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_cnt   <= '0;
`ifdef BCD_DIGIT_CHECK_EN
      r_bad   <= 1'b0;
      r_err   <= 1'b0;
`endif
    end else if (r_state == StRun) begin
      r_a     <= r_a >> 4;
      r_b     <= r_b >> 4;
      r_carry <= w_dc;
      r_cnt   <= r_cnt + CntW'(1);
      r_acc   <= w_acc_next;
`ifdef BCD_DIGIT_CHECK_EN
      r_bad   <= r_bad | w_digit_bad;
      if (w_last) begin
        if (r_bad || w_digit_bad) begin
          r_err <= 1'b1;
        end else begin
          r_sum  <= w_acc_next;
          r_cout <= w_dc;
        end
      end
`else
      if (w_last) begin
        r_sum  <= w_acc_next;
        r_cout <= w_dc;
      end
`endif
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Randomised self-checking bench for bcd_serial_add_ctrl against a decimal-arithmetic model.
// Exercises BCD_DIGIT_CHECK_EN behaviour when that macro is defined for the build.
module tb_bcd_serial_add_ctrl;

  localparam int unsigned Digits = 4;
  localparam int unsigned W      = 4 * Digits;
`ifdef BCD_DIGIT_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  logic       start1;
  logic [3:0] a1;
  logic [3:0] b1;
  logic       cin1;
  logic       busy1;
  logic       done1;
  logic [3:0] sum1;
  logic       cout1;
  logic       err1;

  int n_checks;
  int n_fail;

  logic [W-1:0] exp_sum;
  logic         exp_cout;
  logic         exp_err;
  bit           exp_known;

  bcd_serial_add_ctrl #(.DIGITS(Digits)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  bcd_serial_add_ctrl #(.DIGITS(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1),
    .err   (err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic longint unsigned bcd2int(input logic [63:0] v, input int nd);
    longint unsigned r = 0;
    for (int i = nd - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [63:0] int2bcd(input longint unsigned x, input int nd);
    logic [63:0] r = '0;
    longint unsigned t = x;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit has_illegal(input logic [63:0] v, input int nd);
    bit bad = 1'b0;
    for (int i = 0; i < nd; i++) if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < Digits; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Decimal model: add as integers, split back into digits and a carry.
  task automatic model_add(input logic [63:0] aa, input logic [63:0] bb, input logic c,
                           input int nd, output logic [63:0] s, output logic co);
    longint unsigned modv = 1;
    longint unsigned tot;
    for (int i = 0; i < nd; i++) modv = modv * 10;
    tot = bcd2int(aa, nd) + bcd2int(bb, nd) + longint'(c);
    s   = int2bcd(tot % modv, nd);
    co  = (tot >= modv);
  endtask

  task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic c);
    logic [63:0] ms;
    logic        mc;
    bit          bad;
    logic [W-1:0] old_sum;
    bit           old_known;
    bad       = has_illegal(64'(aa), Digits) || has_illegal(64'(bb), Digits);
    old_sum   = exp_sum;
    old_known = exp_known;
    model_add(64'(aa), 64'(bb), c, Digits, ms, mc);
    @(negedge clk);
    a = aa; b = bb; cin = c; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
    if (!bad) begin
      exp_sum = W'(ms); exp_cout = mc; exp_known = 1'b1; exp_err = 1'b0;
    end else if (ChkEn) begin
      exp_err = 1'b1;
    end else begin
      exp_known = 1'b0; exp_err = 1'b0;
    end
    for (int k = 1; k <= Digits; k++) begin
      @(negedge clk);
      check_eq("busy_run", 64'(busy), 64'd1);
      check_eq("done_run", 64'(done), 64'd0);
      if (k == 1 && old_known) check_eq("sum_hold", 64'(sum), 64'(old_sum));
    end
    @(negedge clk);
    check_eq("busy_done", 64'(busy), 64'd0);
    check_eq("done_pulse", 64'(done), 64'd1);
    check_eq("err", 64'(err), 64'(exp_err));
    if (exp_known) begin
      check_eq("sum", 64'(sum), 64'(exp_sum));
      check_eq("cout", 64'(cout), 64'(exp_cout));
    end
    @(negedge clk);
    check_eq("done_clear", 64'(done), 64'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_sum   = '0;
    exp_cout  = 1'b0;
    exp_err   = 1'b0;
    exp_known = 1'b1;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_sum", 64'(sum), 64'd0);
    check_eq("rst_cout", 64'(cout), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h5678, 1'b0);
    check_eq("t1_sum_const", 64'(sum), 64'h6912);
    run_op(16'h9999, 16'h0001, 1'b0);
    check_eq("t2_cout_const", 64'(cout), 64'd1);
    run_op(16'h0000, 16'h0000, 1'b1);
    check_eq("t2b_sum_const", 64'(sum), 64'h0001);

    // start held high: runs accepted at E0 and E6, nothing queued in between
    @(negedge clk);
    a = 16'h0005; b = 16'h0005; cin = 1'b0; start = 1'b1;
    for (int e = 0; e < 12; e++) begin
      int m;
      @(posedge clk);
      if (e == 9) begin
        #1;
        start = 1'b0;
      end
      @(negedge clk);
      m = (e + 1) % 6;
      check_eq("hold_busy", 64'(busy), 64'((m >= 1) && (m <= 4)));
      check_eq("hold_done", 64'(done), 64'(m == 5));
      if (m == 5) check_eq("hold_sum", 64'(sum), 64'h0010);
    end
    exp_sum = 16'h0010; exp_cout = 1'b0;

    // reset during RUN cycle 2
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_done", 64'(done), 64'd0);
    check_eq("abort_sum", 64'(sum), 64'd0);
    check_eq("abort_cout", 64'(cout), 64'd0);
    rst_n = 1'b1;
    exp_sum = '0; exp_cout = 1'b0; exp_err = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("abort_nodone", 64'(done), 64'd0);
    end
    run_op(16'h0456, 16'h0544, 1'b0);

    // illegal digit: flagged with the check built, timing unchanged otherwise
    run_op(16'h12A4, 16'h0000, 1'b0);
    run_op(16'h0042, 16'h0058, 1'b1);

    for (int n = 0; n < 25; n++) begin
      run_op(rand_bcd(), rand_bcd(), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // single-digit instance
    for (int n = 0; n < 6; n++) begin
      logic [3:0]  ta;
      logic [3:0]  tb;
      logic        tc;
      logic [63:0] ms;
      logic        mc;
      if (n == 0) begin
        ta = 4'h8; tb = 4'h7; tc = 1'b0;
      end else begin
        ta = 4'($urandom_range(0, 9)); tb = 4'($urandom_range(0, 9)); tc = 1'($urandom);
      end
      model_add(64'(ta), 64'(tb), tc, 1, ms, mc);
      @(negedge clk);
      a1 = ta; b1 = tb; cin1 = tc; start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      @(negedge clk);
      check_eq("d1_busy", 64'(busy1), 64'd1);
      check_eq("d1_done_early", 64'(done1), 64'd0);
      @(negedge clk);
      check_eq("d1_done", 64'(done1), 64'd1);
      check_eq("d1_sum", 64'(sum1), ms);
      check_eq("d1_cout", 64'(cout1), 64'(mc));
      check_eq("d1_err", 64'(err1), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
